// File: rtl/aui_lane_deskew_if.sv
// Lane bundle between lane recovery and the deskew stage, plus the deskewed
// output and status toward block reassembly.
interface aui_lane_deskew_if #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned LANE_WIDTH = 1360
);
  logic [NUM_LANES*LANE_WIDTH-1:0] i_lanes;
  logic [NUM_LANES-1:0]            i_sync;
  logic                            i_valid;
  logic                            i_resync;
  logic [NUM_LANES*LANE_WIDTH-1:0] o_lanes;
  logic [NUM_LANES-1:0]            o_sync;
  logic                            o_valid;
  logic                            o_locked;
  logic                            o_align_err;
  logic                            o_skew_err;
  logic [15:0]                     o_realign_cnt;

  modport master (
    output i_lanes, i_sync, i_valid, i_resync,
    input  o_lanes, o_sync, o_valid, o_locked, o_align_err, o_skew_err, o_realign_cnt
  );

  modport slave (
    input  i_lanes, i_sync, i_valid, i_resync,
    output o_lanes, o_sync, o_valid, o_locked, o_align_err, o_skew_err, o_realign_cnt
  );
endinterface

// File: rtl/aui_lane_deskew.sv
// Per-lane FIFO deskew: searches for a marker on every lane, then pops all
// lanes together and watches that the popped marker flags stay aligned.
module aui_lane_deskew #(
  parameter int unsigned NUM_LANES  = 16,
  parameter int unsigned LANE_WIDTH = 1360,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  aui_lane_deskew_if.slave bus
);
  localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = LANE_WIDTH + 1;
  localparam int unsigned BUS_W   = NUM_LANES * LANE_WIDTH;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  state_e               state_q;
  logic [ENTRY_W-1:0]   mem_q    [NUM_LANES][FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q [NUM_LANES];
  logic [PTR_W-1:0]     rd_ptr_q [NUM_LANES];
  logic [OCC_W-1:0]     occ_q    [NUM_LANES];

  logic [BUS_W-1:0]     lanes_q;
  logic [NUM_LANES-1:0] sync_q;
  logic                 valid_q;
  logic                 locked_q;
  logic                 align_err_q;
  logic                 skew_err_q;
  logic [15:0]          realign_cnt_q;

  logic                 all_nonempty;
  logic                 any_full;
  logic                 pop;
  logic                 pop_go;
  logic                 mismatch;
  logic                 overflow;
  logic                 flush;
  logic [NUM_LANES-1:0] head_sync;
  logic [NUM_LANES-1:0] wr_en;
  logic [BUS_W-1:0]     head_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO status, head words and the event decode for this cycle
  always_comb begin
    all_nonempty = 1'b1;
    any_full     = 1'b0;
    head_sync    = '0;
    head_data    = '0;
    wr_en        = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (occ_q[l] == '0) all_nonempty = 1'b0;
      if (occ_q[l] == OCC_W'(FIFO_DEPTH)) any_full = 1'b1;
      head_sync[l] = mem_q[l][rd_ptr_q[l]][LANE_WIDTH];
      head_data[l*LANE_WIDTH +: LANE_WIDTH] = mem_q[l][rd_ptr_q[l]][LANE_WIDTH-1:0];
    end
    pop      = (state_q == LOCKED) && all_nonempty;
    mismatch = pop && (head_sync != '0) && (head_sync != '1);
    // A full FIFO in SEARCH can never take another word (no pop until locked),
    // so a full lane is treated as overflow even in the cycle all lanes arm.
    overflow = (state_q == SEARCH) && bus.i_valid && any_full;
    flush    = bus.i_resync || mismatch || overflow;
    pop_go   = pop && !flush;
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_en[l] = bus.i_valid && !flush &&
                 ((state_q == LOCKED) || (occ_q[l] != '0) || bus.i_sync[l]);
    end
  end

  // Lane storage; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (wr_en[l]) begin
        mem_q[l][wr_ptr_q[l]] <= {bus.i_sync[l], bus.i_lanes[l*LANE_WIDTH +: LANE_WIDTH]};
      end
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (rst || flush) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        occ_q[l]    <= '0;
      end else begin
        if (wr_en[l]) wr_ptr_q[l] <= ptr_inc(wr_ptr_q[l]);
        if (pop_go)   rd_ptr_q[l] <= ptr_inc(rd_ptr_q[l]);
        occ_q[l] <= occ_q[l] + OCC_W'(wr_en[l]) - OCC_W'(pop_go);
      end
    end
  end

  // Lock FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEARCH;
      lanes_q       <= '0;
      sync_q        <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      align_err_q   <= 1'b0;
      skew_err_q    <= 1'b0;
      realign_cnt_q <= '0;
    end else begin
      valid_q     <= 1'b0;
      align_err_q <= 1'b0;
      skew_err_q  <= 1'b0;
      if (state_q == SEARCH) begin
        if (bus.i_resync) begin
          state_q <= SEARCH;
        end else if (overflow) begin
          skew_err_q <= 1'b1;
        end else if (all_nonempty) begin
          state_q  <= LOCKED;
          locked_q <= 1'b1;
        end
      end else begin
        if (bus.i_resync || mismatch) begin
          state_q     <= SEARCH;
          locked_q    <= 1'b0;
          align_err_q <= mismatch && !bus.i_resync;
          if (realign_cnt_q != 16'hFFFF) realign_cnt_q <= realign_cnt_q + 16'd1;
        end else if (pop) begin
          lanes_q <= head_data;
          sync_q  <= head_sync;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_lanes       = lanes_q;
  assign bus.o_sync        = sync_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_locked      = locked_q;
  assign bus.o_align_err   = align_err_q;
  assign bus.o_skew_err    = skew_err_q;
  assign bus.o_realign_cnt = realign_cnt_q;

endmodule

// File: tb/tb_aui_lane_deskew.sv
// Directed vector bench for aui_lane_deskew: lock, skew, gaps, mismatch,
// resync, reset and overflow with hand-computed expected outputs.
module tb_aui_lane_deskew;
  localparam int unsigned NL = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned FD = 8;
  localparam int unsigned BW = NL * LW;

  localparam logic [NL-1:0] A  = 16'hFFFF;
  localparam logic [NL-1:0] Z  = 16'h0000;
  localparam logic [NL-1:0] M2 = 16'hFFFB;
  localparam logic [NL-1:0] S5 = 16'hFFDF;
  localparam logic [NL-1:0] L5 = 16'h0020;
  localparam logic [NL-1:0] N9 = 16'hFDFF;

  typedef struct {
    logic          rst;
    logic          valid;
    logic          resync;
    logic [NL-1:0] sync;
    logic          ev;
    logic [NL-1:0] es;
    logic [7:0]    est;
    logic [7:0]    est5;
    logic          el;
    logic          eae;
    logic          ese;
    logic [15:0]   ecnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aui_lane_deskew_if #(.NUM_LANES(NL), .LANE_WIDTH(LW)) bus ();

  aui_lane_deskew #(.NUM_LANES(NL), .LANE_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t          vq[$];
  logic [BW-1:0] held_lanes;
  logic [NL-1:0] held_sync;
  int            n_cmp;
  int            n_bad;

  function automatic vec_t mk(input logic r, input logic v, input logic rs, input logic [NL-1:0] s,
                              input logic ev, input logic [NL-1:0] es, input logic [7:0] est,
                              input logic el, input logic eae, input logic ese, input logic [15:0] cnt);
    vec_t x;
    x.rst = r; x.valid = v; x.resync = rs; x.sync = s;
    x.ev = ev; x.es = es; x.est = est; x.est5 = est;
    x.el = el; x.eae = eae; x.ese = ese; x.ecnt = cnt;
    return x;
  endfunction

  function automatic vec_t mk5(input logic [NL-1:0] s, input logic [NL-1:0] es,
                               input logic [7:0] est, input logic [7:0] est5);
    vec_t x;
    x = mk(1'b0, 1'b1, 1'b0, s, 1'b1, es, est, 1'b1, 1'b0, 1'b0, 16'd2);
    x.est5 = est5;
    return x;
  endfunction

  // Lane l word = {lane index, stamp}; lane 5 may carry a different stamp
  function automatic logic [BW-1:0] lanes_of(input logic [7:0] st, input logic [7:0] st5);
    logic [BW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) r[l*LW +: LW] = {8'(l), (l == 5) ? st5 : st};
    return r;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic [7:0] stamp, input string tag);
    rst          = v.rst;
    bus.i_valid  = v.valid;
    bus.i_resync = v.resync;
    bus.i_sync   = v.sync;
    bus.i_lanes  = lanes_of(stamp, stamp);
    @(posedge clk);
    #1;
    if (v.rst) begin
      held_lanes = '0;
      held_sync  = '0;
    end else if (v.ev) begin
      held_lanes = lanes_of(v.est, v.est5);
      held_sync  = v.es;
    end
    check({tag, " o_valid"},       BW'(bus.o_valid),       BW'(v.ev));
    check({tag, " o_locked"},      BW'(bus.o_locked),      BW'(v.el));
    check({tag, " o_align_err"},   BW'(bus.o_align_err),   BW'(v.eae));
    check({tag, " o_skew_err"},    BW'(bus.o_skew_err),    BW'(v.ese));
    check({tag, " o_realign_cnt"}, BW'(bus.o_realign_cnt), BW'(v.ecnt));
    check({tag, " o_sync"},        BW'(bus.o_sync),        BW'(held_sync));
    check({tag, " o_lanes"},       bus.o_lanes,            held_lanes);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    held_lanes = '0;
    held_sync  = '0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_resync = 1'b0;
    bus.i_sync = '0;
    bus.i_lanes = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_valid",       BW'(bus.o_valid),       '0);
    check("reset o_locked",      BW'(bus.o_locked),      '0);
    check("reset o_align_err",   BW'(bus.o_align_err),   '0);
    check("reset o_skew_err",    BW'(bus.o_skew_err),    '0);
    check("reset o_realign_cnt", BW'(bus.o_realign_cnt), '0);
    check("reset o_sync",        BW'(bus.o_sync),        '0);
    check("reset o_lanes",       bus.o_lanes,            '0);

    // zero skew lock at row 1, then steady stream with gaps
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd0));  // 0
    vq.push_back(mk(0, 1, 0, A, 0, Z, 8'd0,  0, 0, 0, 16'd0));  // 1
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd0));  // 2
    vq.push_back(mk(0, 1, 0, Z, 1, A, 8'd1,  1, 0, 0, 16'd0));  // 3
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd2,  1, 0, 0, 16'd0));  // 4
    vq.push_back(mk(0, 1, 0, A, 1, Z, 8'd3,  1, 0, 0, 16'd0));  // 5
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd4,  1, 0, 0, 16'd0));  // 6
    vq.push_back(mk(0, 1, 0, Z, 1, A, 8'd5,  1, 0, 0, 16'd0));  // 7
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd6,  1, 0, 0, 16'd0));  // 8
    vq.push_back(mk(0, 0, 0, Z, 1, Z, 8'd7,  1, 0, 0, 16'd0));  // 9
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd8,  1, 0, 0, 16'd0));  // 10
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd10, 1, 0, 0, 16'd0));  // 11
    vq.push_back(mk(0, 1, 0, A, 1, Z, 8'd11, 1, 0, 0, 16'd0));  // 12
    vq.push_back(mk(0, 0, 0, Z, 1, A, 8'd12, 1, 0, 0, 16'd0));  // 13
    vq.push_back(mk(0, 0, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd0));  // 14
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd0));  // 15
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd15, 1, 0, 0, 16'd0));  // 16
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd16, 1, 0, 0, 16'd0));  // 17
    // lane 2 marker missing -> align error, then relock
    vq.push_back(mk(0, 1, 0, M2, 1, Z, 8'd17, 1, 0, 0, 16'd0)); // 18
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 1, 0, 16'd1));  // 19
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd1));  // 20
    vq.push_back(mk(0, 1, 0, A, 0, Z, 8'd0,  0, 0, 0, 16'd1));  // 21
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd1));  // 22
    vq.push_back(mk(0, 1, 0, Z, 1, A, 8'd21, 1, 0, 0, 16'd1));  // 23
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd22, 1, 0, 0, 16'd1));  // 24
    // resync coinciding with a mismatching pop counts once, no align error
    vq.push_back(mk(0, 1, 0, M2, 1, Z, 8'd23, 1, 0, 0, 16'd1)); // 25
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd24, 1, 0, 0, 16'd1));  // 26
    vq.push_back(mk(0, 1, 1, Z, 0, Z, 8'd0,  0, 0, 0, 16'd2));  // 27
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd2));  // 28
    // lane 5 marker three words late
    vq.push_back(mk(0, 1, 0, S5, 0, Z, 8'd0, 0, 0, 0, 16'd2));  // 29
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd2));  // 30
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd2));  // 31
    vq.push_back(mk(0, 1, 0, L5, 0, Z, 8'd0, 0, 0, 0, 16'd2));  // 32
    vq.push_back(mk(0, 1, 0, S5, 0, Z, 8'd0, 1, 0, 0, 16'd2));  // 33
    vq.push_back(mk5(Z,  A, 8'd29, 8'd32));                     // 34
    vq.push_back(mk5(Z,  Z, 8'd30, 8'd33));                     // 35
    vq.push_back(mk5(L5, Z, 8'd31, 8'd34));                     // 36
    vq.push_back(mk5(Z,  Z, 8'd32, 8'd35));                     // 37
    vq.push_back(mk5(Z,  A, 8'd33, 8'd36));                     // 38
    vq.push_back(mk5(Z,  Z, 8'd34, 8'd37));                     // 39
    // third realign, relock, then reset mid-lock and relock
    vq.push_back(mk(0, 1, 1, Z, 0, Z, 8'd0,  0, 0, 0, 16'd3));  // 40
    vq.push_back(mk(0, 1, 0, A, 0, Z, 8'd0,  0, 0, 0, 16'd3));  // 41
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd3));  // 42
    vq.push_back(mk(0, 1, 0, Z, 1, A, 8'd41, 1, 0, 0, 16'd3));  // 43
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd42, 1, 0, 0, 16'd3));  // 44
    vq.push_back(mk(1, 1, 0, Z, 0, Z, 8'd0,  0, 0, 0, 16'd0));  // 45
    vq.push_back(mk(0, 1, 0, A, 0, Z, 8'd0,  0, 0, 0, 16'd0));  // 46
    vq.push_back(mk(0, 1, 0, Z, 0, Z, 8'd0,  1, 0, 0, 16'd0));  // 47
    vq.push_back(mk(0, 1, 0, Z, 1, A, 8'd46, 1, 0, 0, 16'd0));  // 48
    vq.push_back(mk(0, 1, 0, Z, 1, Z, 8'd47, 1, 0, 0, 16'd0));  // 49

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], 8'(i), $sformatf("row%0d", i));
    end

    // Overflow: lane 9 never marks while the other lanes fill to depth
    apply(mk(0, 1, 1, Z,  0, Z, 8'd0, 0, 0, 0, 16'd1), 8'd100, "ovf_resync");
    apply(mk(0, 1, 0, N9, 0, Z, 8'd0, 0, 0, 0, 16'd1), 8'd101, "ovf_marker");
    for (int k = 1; k <= 8; k++) begin
      apply(mk(0, 1, 0, Z, 0, Z, 8'd0, 0, 0, (k == 8), 16'd1), 8'(101 + k),
            $sformatf("ovf_fill%0d", k));
    end
    apply(mk(0, 1, 0, Z, 0, Z, 8'd0,   0, 0, 0, 16'd1), 8'd110, "ovf_after");
    apply(mk(0, 1, 0, A, 0, Z, 8'd0,   0, 0, 0, 16'd1), 8'd120, "ovf_relock_mark");
    apply(mk(0, 1, 0, Z, 0, Z, 8'd0,   1, 0, 0, 16'd1), 8'd121, "ovf_relock");
    apply(mk(0, 1, 0, Z, 1, A, 8'd120, 1, 0, 0, 16'd1), 8'd122, "ovf_first_out");
    apply(mk(0, 1, 0, Z, 1, Z, 8'd121, 1, 0, 0, 16'd1), 8'd123, "ovf_second_out");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
